// File: rtl/pp_stream_feeder_pkg.sv
// rtl/pp_stream_feeder_pkg.sv - shared types, sizes and column geometry for the partial-product feeder
package pp_stream_pkg;

  localparam int N_DEF = 11;
  localparam int COLS  = 2 * N_DEF - 1;
  localparam int RES_W = 2 * N_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  function automatic int col_height(input int c, input int n);
    return (c < n) ? c + 1 : 2 * n - 1 - c;
  endfunction

  // Row (a-operand bit) contributing bit j of column c; the b bit is c minus this.
  function automatic int row_index(input int c, input int j, input int n);
    return (c < n) ? j : c - n + 1 + j;
  endfunction

endpackage

// File: rtl/pp_stream_feeder_if.sv
// rtl/pp_stream_feeder_if.sv - operand/product handshake bundle between harness and feeder
interface pp_stream_feeder_if;
  import pp_stream_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [N_DEF-1:0] a;
  logic [N_DEF-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] prod;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, busy
  );

endinterface

// File: rtl/pp_stream_feeder_column_mux.sv
// rtl/pp_stream_feeder_column_mux.sv - selects one column's partial-product bit for feed cycle k
module pp_column_mux
  import pp_stream_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int C  = 0,
  parameter int KW = $clog2(N)
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [KW-1:0] k,
  input  logic          feed_en,
  output logic          bit_o
);

  localparam int H   = col_height(C, N);
  // Short columns start late so that exactly their last H shifts carry data.
  localparam int OFF = N - H;

  logic unused_ops;
  assign unused_ops = ^{a, b};

  always_comb begin
    bit_o = 1'b0;
    for (int j = 0; j < H; j++) begin
      if (feed_en && (k == KW'(OFF + j))) begin
        bit_o = a[row_index(C, j, N)] & b[C - row_index(C, j, N)];
      end
    end
  end

endmodule

// File: rtl/pp_stream_feeder.sv
// rtl/pp_stream_feeder.sv - feeds AND-array columns serially and captures the compressed product
// Optional build macro: PP_FEEDER_SELF_CHECK_EN adds a reference product, mismatch and err_cnt.
module pp_stream_feeder
  import pp_stream_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  pp_stream_feeder_if.slave bus,
  output logic src0_,  output logic src1_,  output logic src2_,  output logic src3_,
  output logic src4_,  output logic src5_,  output logic src6_,  output logic src7_,
  output logic src8_,  output logic src9_,  output logic src10_, output logic src11_,
  output logic src12_, output logic src13_, output logic src14_, output logic src15_,
  output logic src16_, output logic src17_, output logic src18_, output logic src19_,
  output logic src20_,
  input  logic dst0,  input  logic dst1,  input  logic dst2,  input  logic dst3,
  input  logic dst4,  input  logic dst5,  input  logic dst6,  input  logic dst7,
  input  logic dst8,  input  logic dst9,  input  logic dst10, input  logic dst11,
  input  logic dst12, input  logic dst13, input  logic dst14, input  logic dst15,
  input  logic dst16, input  logic dst17, input  logic dst18, input  logic dst19,
  input  logic dst20, input  logic dst21
`ifdef PP_FEEDER_SELF_CHECK_EN
  ,
  output logic        mismatch,
  output logic [15:0] err_cnt
`endif
);

  localparam int C_W = 2 * N - 1;
  localparam int R_W = 2 * N;
  localparam int KW  = $clog2(N);
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [SW-1:0]  st_q, st_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [R_W-1:0] prod_q, prod_d;
  logic           out_valid_q, out_valid_d;
  logic [C_W-1:0] src_vec;
  logic [R_W-1:0] dst_vec;
  logic           accept;
  logic           feed_en;

`ifdef PP_FEEDER_SELF_CHECK_EN
  logic [R_W-1:0] exp_q, exp_d;
  logic           mismatch_q, mismatch_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
`endif

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign feed_en       = (state_q == S_FEED);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    st_d        = st_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
`ifdef PP_FEEDER_SELF_CHECK_EN
    exp_d       = exp_q;
    mismatch_d  = mismatch_q;
    err_cnt_d   = err_cnt_q;
`endif

    // accept can only fire in IDLE or in the DONE cycle that releases the product
    if (accept) begin
      a_d = bus.a;
      b_d = bus.b;
      k_d = '0;
`ifdef PP_FEEDER_SELF_CHECK_EN
      exp_d = R_W'(bus.a) * R_W'(bus.b);
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_FEED;
      end
      S_FEED: begin
        if (k_q == KW'(N - 1)) begin
          st_d    = '0;
          state_d = S_SETTLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (st_q == SW'(SETTLE - 1)) state_d = S_CAPTURE;
        else                          st_d    = st_q + 1'b1;
      end
      S_CAPTURE: begin
        prod_d      = dst_vec;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
`ifdef PP_FEEDER_SELF_CHECK_EN
        if (dst_vec != exp_q) begin
          mismatch_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
`endif
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? S_FEED : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      st_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef PP_FEEDER_SELF_CHECK_EN
      exp_q       <= '0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      st_q        <= st_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
`ifdef PP_FEEDER_SELF_CHECK_EN
      exp_q       <= exp_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

`ifdef PP_FEEDER_SELF_CHECK_EN
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
`endif

  for (genvar c = 0; c < C_W; c++) begin : g_col
    pp_column_mux #(.N(N), .C(c), .KW(KW)) u_mux (
      .a       (a_q),
      .b       (b_q),
      .k       (k_q),
      .feed_en (feed_en),
      .bit_o   (src_vec[c])
    );
  end

  assign src0_  = src_vec[0];
  assign src1_  = src_vec[1];
  assign src2_  = src_vec[2];
  assign src3_  = src_vec[3];
  assign src4_  = src_vec[4];
  assign src5_  = src_vec[5];
  assign src6_  = src_vec[6];
  assign src7_  = src_vec[7];
  assign src8_  = src_vec[8];
  assign src9_  = src_vec[9];
  assign src10_ = src_vec[10];
  assign src11_ = src_vec[11];
  assign src12_ = src_vec[12];
  assign src13_ = src_vec[13];
  assign src14_ = src_vec[14];
  assign src15_ = src_vec[15];
  assign src16_ = src_vec[16];
  assign src17_ = src_vec[17];
  assign src18_ = src_vec[18];
  assign src19_ = src_vec[19];
  assign src20_ = src_vec[20];

  assign dst_vec = {dst21, dst20, dst19, dst18, dst17, dst16, dst15, dst14, dst13, dst12, dst11,
                    dst10, dst9, dst8, dst7, dst6, dst5, dst4, dst3, dst2, dst1, dst0};

endmodule

// File: tb/tb_pp_stream_feeder.sv
// tb/tb_pp_stream_feeder.sv - directed bench with a gated shift-register and popcount compressor harness
module tb_pp_stream_feeder;
  import pp_stream_pkg::*;

  localparam int N = N_DEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] src;
  logic [21:0] dst;
  logic [21:0] dst_sum;
  logic [10:0] sr [21];
  int          shift_left;
  logic        force_dst5 = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;
  logic [20:0] src_k0, src_k10;
  logic [10:0] col0_bits;
`ifdef PP_FEEDER_SELF_CHECK_EN
  logic        mismatch;
  logic [15:0] err_cnt;
`endif

  pp_stream_feeder_if bus ();

  always #5 clk = ~clk;

  pp_stream_feeder dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .src0_(src[0]),   .src1_(src[1]),   .src2_(src[2]),   .src3_(src[3]),
    .src4_(src[4]),   .src5_(src[5]),   .src6_(src[6]),   .src7_(src[7]),
    .src8_(src[8]),   .src9_(src[9]),   .src10_(src[10]), .src11_(src[11]),
    .src12_(src[12]), .src13_(src[13]), .src14_(src[14]), .src15_(src[15]),
    .src16_(src[16]), .src17_(src[17]), .src18_(src[18]), .src19_(src[19]),
    .src20_(src[20]),
    .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),
    .dst4(dst[4]),   .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),
    .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
    .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]),
    .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
    .dst20(dst[20]), .dst21(dst[21])
`ifdef PP_FEEDER_SELF_CHECK_EN
    , .mismatch(mismatch), .err_cnt(err_cnt)
`endif
  );

  // Harness: shift enable is gated for exactly N cycles after each accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_left <= 0;
    end else begin
      if (bus.in_valid && bus.in_ready) shift_left <= N;
      else if (shift_left != 0)         shift_left <= shift_left - 1;
      if (shift_left != 0)
        for (int c = 0; c < 21; c++) sr[c] <= {sr[c][9:0], src[c]};
    end
  end

  always_comb begin
    dst_sum = '0;
    for (int c = 0; c < 21; c++)
      for (int j = 0; j < 11; j++)
        if (j < col_height(c, N)) dst_sum = dst_sum + (22'(sr[c][j]) << c);
    dst = dst_sum;
    if (force_dst5) dst[5] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy), 32'd0);
    chk({tag, "_prod"},      32'(bus.prod), 32'd0);
    chk({tag, "_src"},       32'(src), 32'd0);
  endtask

  task automatic start_op(input logic [10:0] ta, input logic [10:0] tb, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = ta; bus.b = tb;
    #1 chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.a = ~ta; bus.b = ~tb;
  endtask

  task automatic wait_result(input logic [21:0] texp, input string tag);
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      if (cyc == 0)  src_k0 = src;
      if (cyc == 10) src_k10 = src;
      if (cyc < 11)  col0_bits[cyc] = src[0];
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd13);
    chk({tag, "_prod"}, 32'(bus.prod), 32'(texp));
  endtask

  task automatic consume(input string tag);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [10:0] ra, rb;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst_rel");

    start_op(11'd3, 11'd5, "op3x5");
    wait_result(22'd15, "op3x5");
    chk("op3x5_col0", 32'(col0_bits), 32'h400);
    chk("op3x5_k0", 32'(src_k0), 32'h0);
    chk("op3x5_k10", 32'(src_k10), 32'h3);
    consume("op3x5");

    start_op(11'h7FF, 11'h7FF, "ones");
    wait_result(22'h3FF001, "ones");
    chk("ones_k0", 32'(src_k0), 32'h400);
    chk("ones_k10", 32'(src_k10), 32'h1FFFFF);
    consume("ones");
    start_op(11'h000, 11'h7FF, "stale");
    wait_result(22'h0, "stale");
    chk("stale_k10", 32'(src_k10), 32'h0);
    consume("stale");

    start_op(11'h7FF, 11'h001, "hold");
    wait_result(22'h7FF, "hold");
    bus.in_valid = 1'b1; bus.a = 11'd5; bus.b = 11'd9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_state", {bus.out_valid, bus.in_ready, 8'(src != 0), 22'(bus.prod)},
          {1'b1, 1'b0, 8'd0, 22'h7FF});
    end
    consume("hold");

    start_op(11'd3, 11'd5, "b2b_first");
    wait_result(22'd15, "b2b_first");
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.a = 11'd2; bus.b = 11'd3;
    #1 chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = 11'h7FF; bus.b = 11'h7FF;
    chk("b2b_feed", {bus.busy, bus.out_valid, bus.in_ready}, 32'b100);
    wait_result(22'd6, "b2b_second");
    consume("b2b_second");

    start_op(11'h7FF, 11'h7FF, "midrst");
    repeat (5) @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1 chk_idle("midrst_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("midrst_after");
    start_op(11'h7FF, 11'h7FF, "postrst");
    wait_result(22'h3FF001, "postrst");
    consume("postrst");

    start_op(11'h400, 11'h400, "msb");
    wait_result(22'h100000, "msb");
    consume("msb");

`ifdef PP_FEEDER_SELF_CHECK_EN
    for (int i = 0; i < 1000; i++) begin
      ra = 11'($urandom_range(0, 2047));
      rb = 11'($urandom_range(0, 2047));
      start_op(ra, rb, "rand");
      wait_result({11'd0, ra} * {11'd0, rb}, "rand");
      consume("rand");
    end
    chk("sc_clean", {15'd0, mismatch, err_cnt}, 32'd0);
    force_dst5 = 1'b1;
    start_op(11'd32, 11'd1, "stuck5");
    wait_result(22'd0, "stuck5");
    consume("stuck5");
    chk("sc_stuck", {15'd0, mismatch, err_cnt}, {15'd0, 1'b1, 16'd1});
    force_dst5 = 1'b0;
`else
    ra = 11'd0;
    rb = 11'd0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
